keyboard_cnt_multi: RTL and testbench
=====================================

Name: keyboard_cnt_multi

Overview:
Per-key press counter and checker for the piano game, one counter per channel. Counts rising edges of each key's press line within a measure. At the measure boundary it compares each count against that key's expected count, latches a per-key wrong flag, and adds the number of mismatching keys to a saturating error total. It sits between the keyboard debouncers and the score/display logic, driven by the beat counter and by the game-control stop/restart signals.

Parameters:
NUM_KEYS, 4, number of independent key channels
CNT_W, 7, width of each per-key press counter and expected-count field
BEAT_W, 7, width of beat_cnt
MEASURE_LEN, 96, beat_cnt value that marks the end of a measure
ERR_W, 8, width of the saturating error total

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
restart  input  1  synchronous clear, same effect as reset on the next edge
stop_or_end  input  1  freeze: counters, FSM progress and boundary handling hold
beat_cnt  input  BEAT_W  current beat position from the beat counter
press  input  NUM_KEYS  debounced key levels, bit k = key k
check  input  NUM_KEYS*CNT_W  expected press count per key; key k uses bits [k*CNT_W +: CNT_W]
cnt_out  output  NUM_KEYS*CNT_W  live per-key counts, packed the same way as check
wrong  output  NUM_KEYS  live compare: bit k = (cnt_k != check_k)
measure_wrong  output  NUM_KEYS  per-key result latched at the last measure boundary
measure_done  output  1  one-cycle pulse when a boundary is processed
err_total  output  ERR_W  saturating sum of mismatching keys over all processed measures
state  output  2  FSM state: 0 IDLE, 1 RUN, 2 HOLD

Behaviour:
- Reset (rst=1, async) and restart (sync, checked before all other conditions): all counts 0, press_q 0, beat_q 0, measure_wrong 0, measure_done 0, err_total 0, state IDLE. The live wrong output then equals (check != 0) per key.
- Edge detect: press_q <= press on every non-reset cycle in all states. rise_k = press[k] & ~press_q[k]. A key held across HOLD or IDLE never produces a later edge.
- Boundary event: bnd = (beat_cnt == MEASURE_LEN) && (beat_q != MEASURE_LEN). beat_q <= beat_cnt on every non-reset cycle. A held value of MEASURE_LEN fires only once.
- FSM:
  - IDLE -> RUN when beat_cnt == 0 and stop_or_end == 0. Rises and bnd are ignored in IDLE.
  - RUN -> HOLD when stop_or_end == 1. This takes priority; no count or boundary update happens in that cycle.
  - HOLD -> RUN when stop_or_end == 0. Nothing updates while in HOLD.
- RUN, no bnd: cnt_k <= cnt_k + rise_k, saturating at 2^CNT_W-1 with no wrap.
- RUN with bnd, all in one cycle:
  - measure_wrong <= wrong, using pre-update counts.
  - err_total <= min(err_total + popcount(wrong), 2^ERR_W-1).
  - measure_done <= 1.
  - cnt_k <= rise_k, so a press on the boundary cycle counts toward the new measure.
- measure_done is 0 on every other cycle.
- Latency: a rise at edge n is visible in cnt_out/wrong after edge n. measure_wrong, err_total and measure_done are registered and appear one edge after bnd is sampled.
- Widths: check fields are compared at full CNT_W, and no truncation is allowed. The popcount is NUM_KEYS-wide, zero-extended before the saturating add.

Test Plan:
- Reset, then beat_cnt=0 and stop_or_end=0 -> state RUN next cycle; all cnt_out 0; measure_done 0; err_total 0.
- NUM_KEYS=4, check={0,1,2,3} (key 3..0), key0 pulsed 3 times, key1 2 times, key2 once, key3 0 times, then beat_cnt=96 -> one measure_done pulse; measure_wrong=4'b0000; err_total=0; counts 0 after the boundary.
- Next measure, key0 pressed 1 time (expected 3) and all other keys correct, boundary -> measure_wrong=4'b0001; err_total=1. Hold beat_cnt=96 for 5 cycles -> no second pulse.
- stop_or_end=1 mid-measure with key2 held high, release, then stop_or_end=0 -> counts unchanged; state RUN->HOLD->RUN; no count increment.
- key0 rise on the same cycle as the boundary -> measure_wrong uses the old count; cnt_out key0=1 after the boundary. Separately, 130 pulses on key0 with CNT_W=7 -> count saturates at 127.
- ERR_W=3, four full-mismatch measures (popcount 4 each) -> err_total 4, then 7, then stays at 7. Assert rst mid-measure -> all outputs return to reset values immediately, with no clock edge needed.

Source files
------------

// File: rtl/keyboard_cnt_multi.sv
// Per-key press counter for the piano game: counts rising edges of each key per measure,
// latches per-key mismatch flags at the measure boundary and accumulates a saturating error total.
module keyboard_cnt_multi #(
    parameter int NUM_KEYS    = 4,
    parameter int CNT_W       = 7,
    parameter int BEAT_W      = 7,
    parameter int MEASURE_LEN = 96,
    parameter int ERR_W       = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      restart,
    input  logic                      stop_or_end,
    input  logic [BEAT_W-1:0]         beat_cnt,
    input  logic [NUM_KEYS-1:0]       press,
    input  logic [NUM_KEYS*CNT_W-1:0] check,
    output logic [NUM_KEYS*CNT_W-1:0] cnt_out,
    output logic [NUM_KEYS-1:0]       wrong,
    output logic [NUM_KEYS-1:0]       measure_wrong,
    output logic                      measure_done,
    output logic [ERR_W-1:0]          err_total,
    output logic [1:0]                state
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    localparam int PC_W  = $clog2(NUM_KEYS + 1);
    localparam int SUM_W = ((ERR_W > PC_W) ? ERR_W : PC_W) + 1;

    localparam logic [BEAT_W-1:0] MEAS    = BEAT_W'(MEASURE_LEN);
    localparam logic [SUM_W-1:0]  ERR_MAX = {{(SUM_W-ERR_W){1'b0}}, {ERR_W{1'b1}}};

    logic [1:0]                     state_q, state_d;
    logic [NUM_KEYS-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [NUM_KEYS-1:0]            press_q;
    logic [BEAT_W-1:0]              beat_q;
    logic [NUM_KEYS-1:0]            measure_wrong_q, measure_wrong_d;
    logic                           measure_done_q, measure_done_d;
    logic [ERR_W-1:0]               err_q, err_d;

    logic [NUM_KEYS-1:0] rise;
    logic [NUM_KEYS-1:0] wrong_w;
    logic                bnd;
    logic [PC_W-1:0]     pop;
    logic [SUM_W-1:0]    err_sum;
    logic [ERR_W-1:0]    err_sat;

    assign rise = press & ~press_q;
    // beat_q suppresses repeat boundaries while beat_cnt sits at MEASURE_LEN
    assign bnd  = (beat_cnt == MEAS) && (beat_q != MEAS);

    always_comb begin
        wrong_w = '0;
        pop     = '0;
        for (int unsigned k = 0; k < NUM_KEYS; k++) begin
            wrong_w[k] = (cnt_q[k] != check[k*CNT_W +: CNT_W]);
            pop        = pop + PC_W'(wrong_w[k]);
        end
        err_sum = SUM_W'(err_q) + SUM_W'(pop);
        err_sat = (err_sum > ERR_MAX) ? ERR_MAX[ERR_W-1:0] : err_sum[ERR_W-1:0];
    end

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        measure_wrong_d = measure_wrong_q;
        measure_done_d  = 1'b0;
        err_d           = err_q;
        case (state_q)
            S_IDLE: begin
                if ((beat_cnt == '0) && !stop_or_end) state_d = S_RUN;
            end
            S_RUN: begin
                if (stop_or_end) begin
                    state_d = S_HOLD;
                end else if (bnd) begin
                    measure_wrong_d = wrong_w;
                    measure_done_d  = 1'b1;
                    err_d           = err_sat;
                    for (int unsigned k = 0; k < NUM_KEYS; k++)
                        cnt_d[k] = CNT_W'(rise[k]);
                end else begin
                    for (int unsigned k = 0; k < NUM_KEYS; k++)
                        if (cnt_q[k] != '1) cnt_d[k] = cnt_q[k] + CNT_W'(rise[k]);
                end
            end
            S_HOLD: begin
                if (!stop_or_end) state_d = S_RUN;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= S_IDLE;
            cnt_q           <= '0;
            press_q         <= '0;
            beat_q          <= '0;
            measure_wrong_q <= '0;
            measure_done_q  <= 1'b0;
            err_q           <= '0;
        end else if (restart) begin
            state_q         <= S_IDLE;
            cnt_q           <= '0;
            press_q         <= '0;
            beat_q          <= '0;
            measure_wrong_q <= '0;
            measure_done_q  <= 1'b0;
            err_q           <= '0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            press_q         <= press;
            beat_q          <= beat_cnt;
            measure_wrong_q <= measure_wrong_d;
            measure_done_q  <= measure_done_d;
            err_q           <= err_d;
        end
    end

    assign cnt_out       = cnt_q;
    assign wrong         = wrong_w;
    assign measure_wrong = measure_wrong_q;
    assign measure_done  = measure_done_q;
    assign err_total     = err_q;
    assign state         = state_q;

endmodule

// File: tb/tb_keyboard_cnt_multi.sv
// Directed bench for keyboard_cnt_multi: boundary results go through a scoreboard queue,
// a second instance with ERR_W=3 shares the stimulus to exercise error saturation.
module tb_keyboard_cnt_multi;

    localparam int NK = 4;
    localparam int CW = 7;
    localparam int BW = 7;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            restart = 1'b0;
    logic            stop_or_end = 1'b0;
    logic [BW-1:0]   beat_cnt = '0;
    logic [NK-1:0]   press = '0;
    logic [NK*CW-1:0] check;
    logic [NK*CW-1:0] cnt_out, cnt_out3;
    logic [NK-1:0]   wrong, wrong3, mw, mw3;
    logic            done, done3;
    logic [7:0]      err8;
    logic [2:0]      err3;
    logic [1:0]      state, state3;

    int checks = 0;
    int failures = 0;

    int mc [NK];
    int m_err8 = 0;
    int m_err3 = 0;
    logic [NK-1:0] q_mw [$];
    int            q_e8 [$];
    int            q_e3 [$];

    always #5 clk = ~clk;

    keyboard_cnt_multi dut (
        .clk(clk), .rst(rst), .restart(restart), .stop_or_end(stop_or_end),
        .beat_cnt(beat_cnt), .press(press), .check(check), .cnt_out(cnt_out),
        .wrong(wrong), .measure_wrong(mw), .measure_done(done), .err_total(err8),
        .state(state)
    );

    keyboard_cnt_multi #(.ERR_W(3)) dut3 (
        .clk(clk), .rst(rst), .restart(restart), .stop_or_end(stop_or_end),
        .beat_cnt(beat_cnt), .press(press), .check(check), .cnt_out(cnt_out3),
        .wrong(wrong3), .measure_wrong(mw3), .measure_done(done3), .err_total(err3),
        .state(state3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [NK*CW-1:0] mpack();
        logic [NK*CW-1:0] v;
        v = '0;
        for (int k = 0; k < NK; k++) v[k*CW +: CW] = CW'(mc[k]);
        return v;
    endfunction

    function automatic int chk_val(input int k);
        logic [NK*CW-1:0] c;
        c = check;
        return int'(c[k*CW +: CW]);
    endfunction

    task automatic pulse(input int k);
        press[k] = 1'b1;
        tick();
        press[k] = 1'b0;
        tick();
        if (mc[k] < 127) mc[k] = mc[k] + 1;
    endtask

    task automatic clear_model();
        for (int k = 0; k < NK; k++) mc[k] = 0;
        m_err8 = 0;
        m_err3 = 0;
    endtask

    // Drive one boundary (optionally with simultaneous key rises) and queue its expected result
    task automatic boundary(input logic [NK-1:0] rmask, input int hold);
        logic [NK-1:0] exp_mw;
        int pc;
        pc = 0;
        for (int k = 0; k < NK; k++) begin
            exp_mw[k] = (mc[k] != chk_val(k));
            if (exp_mw[k]) pc++;
        end
        m_err8 = (m_err8 + pc > 255) ? 255 : m_err8 + pc;
        m_err3 = (m_err3 + pc > 7) ? 7 : m_err3 + pc;
        q_mw.push_back(exp_mw);
        q_e8.push_back(m_err8);
        q_e3.push_back(m_err3);
        beat_cnt = BW'(96);
        press = rmask;
        tick();
        press = '0;
        for (int k = 0; k < NK; k++) mc[k] = rmask[k] ? 1 : 0;
        chk("cnt_after_boundary", cnt_out, mpack());
        for (int i = 0; i < hold; i++) begin
            tick();
            chk("no_repeat_done", done, 1'b0);
        end
        beat_cnt = BW'(1);
        tick();
    endtask

    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (q_mw.size() == 0) begin
                chk("spurious_done", done, 1'b0);
            end else begin
                chk("measure_wrong", mw, q_mw.pop_front());
                chk("err_total8", err8, q_e8.pop_front());
                chk("err_total3", err3, q_e3.pop_front());
                chk("done3", done3, 1'b1);
                chk("measure_wrong3", mw3, mw);
            end
        end
    end

    initial begin
        check = {7'd0, 7'd1, 7'd2, 7'd3};
        clear_model();
        tick();
        tick();
        chk("rst_state", state, 2'd0);
        chk("rst_cnt", cnt_out, '0);
        chk("rst_wrong", wrong, 4'b0111);
        chk("rst_done", done, 1'b0);
        chk("rst_err", err8, 8'd0);
        chk("rst_mw", mw, 4'b0000);
        rst = 1'b0;

        // IDLE ignores rises and boundaries
        beat_cnt = BW'(1);
        tick();
        pulse(0);
        mc[0] = 0;
        beat_cnt = BW'(96);
        tick();
        tick();
        chk("idle_state", state, 2'd0);
        chk("idle_cnt", cnt_out, '0);
        beat_cnt = '0;
        tick();
        chk("run_state", state, 2'd1);
        beat_cnt = BW'(1);
        tick();

        // measure 1: all keys correct
        repeat (3) pulse(0);
        repeat (2) pulse(1);
        pulse(2);
        chk("m1_cnt", cnt_out, mpack());
        chk("m1_wrong", wrong, 4'b0000);
        boundary('0, 0);
        chk("m1_err", err8, 8'd0);

        // measure 2: key0 short by two, boundary held for 5 cycles
        pulse(0);
        repeat (2) pulse(1);
        pulse(2);
        chk("m2_wrong", wrong, 4'b0001);
        boundary('0, 4);
        chk("m2_err", err8, 8'd1);

        // stop mid-measure with key2 held, key1 rising during HOLD and held past resume
        pulse(0);
        stop_or_end = 1'b1;
        press[2] = 1'b1;
        tick();
        chk("hold_state", state, 2'd2);
        tick();
        press[2] = 1'b0;
        tick();
        press[1] = 1'b1;
        tick();
        stop_or_end = 1'b0;
        tick();
        chk("resume_state", state, 2'd1);
        tick();
        press[1] = 1'b0;
        tick();
        chk("hold_cnt", cnt_out, mpack());

        // key0 rise coincides with the boundary
        boundary(4'b0001, 0);
        chk("bnd_rise_cnt0", cnt_out[CW-1:0], 7'd1);

        // saturation of key0
        repeat (130) pulse(0);
        chk("sat_cnt0", cnt_out[CW-1:0], 7'd127);
        chk("sat_cnt_all", cnt_out, mpack());
        chk("sat_wrong0", wrong[0], 1'b1);

        // restart, then four full-mismatch measures
        restart = 1'b1;
        tick();
        restart = 1'b0;
        clear_model();
        chk("restart_state", state, 2'd0);
        chk("restart_cnt", cnt_out, '0);
        chk("restart_err8", err8, 8'd0);
        chk("restart_err3", err3, 3'd0);
        beat_cnt = '0;
        tick();
        beat_cnt = BW'(1);
        tick();
        for (int m = 0; m < 4; m++) begin
            pulse(3);
            chk("full_mismatch_wrong", wrong, 4'b1111);
            boundary('0, 0);
        end
        chk("err3_saturated", err3, 3'd7);
        chk("err8_sum", err8, 8'd16);

        // asynchronous reset mid-measure, observed between clock edges
        pulse(0);
        pulse(1);
        #2 rst = 1'b1;
        #1;
        chk("arst_state", state, 2'd0);
        chk("arst_cnt", cnt_out, '0);
        chk("arst_mw", mw, 4'b0000);
        chk("arst_done", done, 1'b0);
        chk("arst_err8", err8, 8'd0);
        chk("arst_err3", err3, 3'd0);
        chk("arst_wrong", wrong, 4'b0111);
        tick();
        rst = 1'b0;
        tick();

        chk("pending_boundaries", q_mw.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
